// File: rtl/cdc_pkg.sv
// Shared types for the req/ack clock-domain-crossing handshake.
// Holds the source-side and sink-side state encodings plus a width helper.
package cdc_pkg;

  // Source (transmit) side handshake states
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    RELEASE = 2'd2
  } hs_tx_state_t;

  // Sink (receive) side counterpart states
  typedef enum logic [1:0] {
    RX_IDLE = 2'd0,
    RX_ACK  = 2'd1,
    RX_WAIT = 2'd2
  } hs_rx_state_t;

  // Counter width able to hold 0..n, never below one bit
  function automatic int cnt_width(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/dual_ff_resync.sv
// Two-flop synchronizer for a single asynchronous bit.
// Reset is asynchronous, active-low, to a configurable value.
module dual_ff_resync #(
  parameter logic RESET_VALUE = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);

  logic meta_q;
  logic sync_q;

  // Two-stage capture of the asynchronous input
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      meta_q <= RESET_VALUE;
      sync_q <= RESET_VALUE;
    end else begin
      meta_q <= i_d;
      sync_q <= meta_q;
    end
  end

  assign o_q = sync_q;

endmodule

// File: rtl/cdc_handshake_tx.sv
// Source side of a four-phase req/ack handshake into a foreign clock domain.
// Word is captured on accept and held on o_data until the next accept.
module cdc_handshake_tx
  import cdc_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 0
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic                  o_req,
  output logic [DATA_WIDTH-1:0] o_data,
  input  logic                  i_ack,
  output logic                  o_done,
  output logic                  o_timeout
);

  localparam int            CW     = cnt_width(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] TO_CNT = CW'(TIMEOUT_CYCLES);
  localparam bit            TO_EN  = (TIMEOUT_CYCLES > 0);

  hs_tx_state_t state_q, state_d;
  logic                  req_q, req_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  done_q, done_d;
  logic                  tout_q, tout_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  ack_s;

  dual_ff_resync #(
    .RESET_VALUE (1'b0)
  ) u_ack_sync (
    .i_clk   (i_clk),
    .i_rst_n (~i_rst),
    .i_d     (i_ack),
    .o_q     (ack_s)
  );

  // Next-state and next-output logic for the handshake walk
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    data_d  = data_q;
    done_d  = 1'b0;
    tout_d  = tout_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (i_valid) begin
          state_d = REQ;
          data_d  = i_data;
          req_d   = 1'b1;
          cnt_d   = '0;
        end
      end
      REQ: begin
        if (TO_EN && (cnt_q != TO_CNT)) begin
          cnt_d = cnt_q + CW'(1);
        end
        if (TO_EN && (cnt_d == TO_CNT)) begin
          tout_d = 1'b1;
        end
        if (ack_s) begin
          state_d = RELEASE;
          req_d   = 1'b0;
          done_d  = 1'b1;
        end
      end
      RELEASE: begin
        // Wait for ack to drop so no stale ack reaches IDLE
        if (!ack_s) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        req_d   = 1'b0;
      end
    endcase
  end

  // State and registered outputs
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      data_q  <= '0;
      done_q  <= 1'b0;
      tout_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      data_q  <= data_d;
      done_q  <= done_d;
      tout_q  <= tout_d;
      cnt_q   <= cnt_d;
    end
  end

  assign o_ready   = (state_q == IDLE);
  assign o_req     = req_q;
  assign o_data    = data_q;
  assign o_done    = done_q;
  assign o_timeout = tout_q;

endmodule

// File: tb/tb_cdc_handshake_tx.sv
// Directed bench for cdc_handshake_tx with a delay-programmable ack model.
// Covers reset, single, back-to-back, stale ack, timeout, reset mid-REQ, random.
module tb_cdc_handshake_tx;

  logic        clk;
  logic        i_rst;
  logic        i_valid;
  logic        o_ready;
  logic [31:0] i_data;
  logic        o_req;
  logic [31:0] o_data;
  logic        i_ack;
  logic        o_done;
  logic        o_timeout;

  int checks = 0;
  int errors = 0;

  int rise_dly = 0;
  int fall_dly = 0;
  bit ack_auto = 1'b0;
  int dcnt     = 0;

  int done_cnt = 0;
  int acc_cnt  = 0;
  logic        prev_req  = 1'b0;
  logic        prev_done = 1'b0;
  logic [31:0] prev_data = '0;

  cdc_handshake_tx #(
    .DATA_WIDTH     (32),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .i_clk     (clk),
    .i_rst     (i_rst),
    .i_valid   (i_valid),
    .o_ready   (o_ready),
    .i_data    (i_data),
    .o_req     (o_req),
    .o_data    (o_data),
    .i_ack     (i_ack),
    .o_done    (o_done),
    .o_timeout (o_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic steps(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic wait_ready(input string tag, input int max);
    int n = 0;
    while (!o_ready && n < max) begin
      steps(1);
      n++;
    end
    chk(tag, o_ready, 1'b1);
  endtask

  task automatic wait_done(input string tag, input int max);
    int n = 0;
    while (!o_done && n < max) begin
      steps(1);
      n++;
    end
    chk(tag, o_done, 1'b1);
  endtask

  // Destination-side ack model, reacting 1ns after each local edge
  always begin
    @(posedge clk);
    #1;
    if (ack_auto) begin
      if (o_req && !i_ack) begin
        if (dcnt >= rise_dly) begin
          i_ack = 1'b1;
          dcnt  = 0;
        end else dcnt++;
      end else if (!o_req && i_ack) begin
        if (dcnt >= fall_dly) begin
          i_ack = 1'b0;
          dcnt  = 0;
        end else dcnt++;
      end else dcnt = 0;
    end
  end

  // Continuous protocol checks
  always @(negedge clk) begin
    if (!i_rst) begin
      if (o_req && prev_req) chk("hold_data", o_data, prev_data);
      if (o_done) begin
        chk("done_vs_ready", o_ready, 1'b0);
        chk("done_twice", prev_done, 1'b0);
        done_cnt++;
      end
      if (i_valid && o_ready) acc_cnt++;
    end
    prev_req  = o_req;
    prev_data = o_data;
    prev_done = o_done;
  end

  initial begin
    int d0;
    int a0;
    logic [31:0] w;
    int n;
    i_rst   = 1'b1;
    i_valid = 1'b0;
    i_data  = '0;
    i_ack   = 1'b0;
    steps(2);
    chk("rst_req", o_req, 1'b0);
    chk("rst_data", o_data, 32'h0);
    chk("rst_ready", o_ready, 1'b1);
    chk("rst_done", o_done, 1'b0);
    chk("rst_tout", o_timeout, 1'b0);
    i_rst = 1'b0;
    steps(1);

    // Single transfer, ack 3 cycles after each req change
    ack_auto = 1'b1;
    rise_dly = 3;
    fall_dly = 3;
    i_valid  = 1'b1;
    i_data   = 32'hDEADBEEF;
    steps(1);
    chk("s_data", o_data, 32'hDEADBEEF);
    chk("s_req", o_req, 1'b1);
    chk("s_ready", o_ready, 1'b0);
    i_valid = 1'b0;
    i_data  = 32'h0;
    steps(5);
    chk("s_req_held", o_req, 1'b1);
    chk("s_no_done", o_done, 1'b0);
    steps(1);
    chk("s_req_fall", o_req, 1'b0);
    chk("s_done", o_done, 1'b1);
    chk("s_data_rel", o_data, 32'hDEADBEEF);
    steps(1);
    chk("s_done_end", o_done, 1'b0);
    steps(4);
    chk("s_not_ready", o_ready, 1'b0);
    steps(1);
    chk("s_ready_back", o_ready, 1'b1);
    chk("s_data_idle", o_data, 32'hDEADBEEF);

    // Back-to-back, fastest ack, accepts 7 cycles apart
    rise_dly = 0;
    fall_dly = 0;
    d0 = done_cnt;
    a0 = acc_cnt;
    i_valid = 1'b1;
    i_data  = 32'h1;
    steps(1);
    chk("b_data1", o_data, 32'h1);
    chk("b_req1", o_req, 1'b1);
    for (int k = 2; k <= 3; k++) begin
      i_data = k;
      steps(5);
      chk("b_busy", o_ready, 1'b0);
      steps(1);
      chk("b_ready", o_ready, 1'b1);
      chk("b_data_prev", o_data, k - 1);
      steps(1);
      chk("b_data", o_data, k);
      chk("b_req", o_req, 1'b1);
    end
    i_valid = 1'b0;
    steps(6);
    chk("b_idle", o_ready, 1'b1);
    chk("b_dones", done_cnt - d0, 3);
    chk("b_accepts", acc_cnt - a0, 3);

    // Stale ack: fall delayed 20 cycles, valid held with next word
    fall_dly = 20;
    i_valid  = 1'b1;
    i_data   = 32'h33;
    steps(1);
    chk("st_data", o_data, 32'h33);
    i_data = 32'h44;
    for (int j = 1; j <= 25; j++) begin
      steps(1);
      chk("st_ready_low", o_ready, 1'b0);
      if (j >= 3) chk("st_req_low", o_req, 1'b0);
    end
    steps(1);
    chk("st_ready", o_ready, 1'b1);
    chk("st_data_hold", o_data, 32'h33);
    steps(1);
    chk("st_next_data", o_data, 32'h44);
    chk("st_next_req", o_req, 1'b1);
    fall_dly = 0;
    i_valid  = 1'b0;
    steps(6);
    chk("st_idle", o_ready, 1'b1);

    // Timeout with ack withheld
    ack_auto = 1'b0;
    i_valid  = 1'b1;
    i_data   = 32'h55;
    steps(1);
    i_valid = 1'b0;
    steps(7);
    chk("to_not_yet", o_timeout, 1'b0);
    steps(1);
    chk("to_set", o_timeout, 1'b1);
    chk("to_req", o_req, 1'b1);
    steps(4);
    chk("to_sticky", o_timeout, 1'b1);
    chk("to_req_held", o_req, 1'b1);
    ack_auto = 1'b1;
    wait_done("to_done", 10);
    chk("to_after_done", o_timeout, 1'b1);
    wait_ready("to_ready", 10);
    chk("to_still", o_timeout, 1'b1);

    // Asynchronous reset two cycles into REQ
    ack_auto = 1'b0;
    i_valid  = 1'b1;
    i_data   = 32'h77;
    steps(1);
    i_valid = 1'b0;
    steps(2);
    chk("r_in_req", o_req, 1'b1);
    #1 i_rst = 1'b1;
    #1;
    chk("r_req", o_req, 1'b0);
    chk("r_data", o_data, 32'h0);
    chk("r_ready", o_ready, 1'b1);
    chk("r_tout", o_timeout, 1'b0);
    steps(1);
    i_rst    = 1'b0;
    ack_auto = 1'b1;
    rise_dly = 2;
    fall_dly = 2;
    i_valid  = 1'b1;
    i_data   = 32'hA5;
    steps(1);
    chk("r_new_data", o_data, 32'hA5);
    chk("r_new_req", o_req, 1'b1);
    i_valid = 1'b0;
    wait_done("r_done", 20);
    wait_ready("r_ready_back", 20);
    chk("r_data_kept", o_data, 32'hA5);

    // Random ack delays over 1000 words
    d0 = done_cnt;
    a0 = acc_cnt;
    for (int i = 0; i < 1000; i++) begin
      rise_dly = $urandom_range(0, 15);
      fall_dly = $urandom_range(0, 15);
      w        = $urandom;
      i_valid  = 1'b1;
      i_data   = w;
      n = 0;
      while (!o_ready && n < 80) begin
        steps(1);
        n++;
      end
      if (!o_ready) chk("rnd_ready", o_ready, 1'b1);
      steps(1);
      chk("rnd_data", o_data, w);
      chk("rnd_req", o_req, 1'b1);
    end
    i_valid = 1'b0;
    wait_ready("rnd_final_ready", 80);
    chk("rnd_done_eq_acc", done_cnt - d0, acc_cnt - a0);
    chk("rnd_accepts", acc_cnt - a0, 1000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
